// File: rtl/lfsr_shift_source.sv
// ============================================================================
// lfsr_shift_source
// ----------------------------------------------------------------------------
// Stimulus source for the 16-bit logical-right barrel shifter. A 16-bit
// maximal-length Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) supplies a
// burst of (data word, shift magnitude) pairs. Each pair is offered with a
// valid/ready handshake. A three-state controller (IDLE -> RUN -> DONE)
// sequences each burst.
//
// Optional build macro:
//   SHIFT_MAG_COUNT_EN  When defined, Shift_Mag comes from a 4-bit counter.
//                       The counter clears on reset and on an accepted Start,
//                       and it increments once per handshake, so a burst
//                       sweeps every magnitude in turn. When the macro is
//                       undefined, Shift_Mag = LFSR[3:0] and no counter exists.
//
// Parameters:
//   DEFAULT_SEED  LFSR value after reset. It also replaces a zero seed.
//   CNT_W         Width of Num_Words and of the remaining-words counter.
//
// Ports:
//   Clk        in   1      system clock, rising edge
//   Rst        in   1      synchronous active-high reset
//   Seed_Load  in   1      load Seed into the LFSR (IDLE only)
//   Seed       in   16     seed value; zero is replaced by DEFAULT_SEED
//   Start      in   1      begin a burst (IDLE only)
//   Num_Words  in   CNT_W  words in the burst, sampled with Start
//   Out_Ready  in   1      downstream accepts the current pair
//   Out_Valid  out  1      Data_Out / Shift_Mag hold a valid pair
//   Data_Out   out  16     current LFSR state
//   Shift_Mag  out  4      shift magnitude for the shifter
//   Busy       out  1      high while in RUN
//   Done       out  1      one-cycle pulse at the end of a burst
// ============================================================================
module lfsr_shift_source #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Seed_Load,
    input  logic [15:0]      Seed,
    input  logic             Start,
    input  logic [CNT_W-1:0] Num_Words,
    input  logic             Out_Ready,
    output logic             Out_Valid,
    output logic [15:0]      Data_Out,
    output logic [3:0]       Shift_Mag,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_remaining;

    logic             w_in_idle;
    logic             w_in_run;
    logic             w_handshake;
    logic             w_last_word;
    logic             w_start_burst;
    logic             w_feedback;
    logic [15:0]      w_lfsr_step;
    logic [15:0]      w_seed_eff;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    assign w_in_idle     = (r_state == S_IDLE);
    assign w_in_run      = (r_state == S_RUN);
    assign w_handshake   = w_in_run & Out_Ready;
    assign w_last_word   = (r_remaining == CNT_W'(1));
    assign w_start_burst = w_in_idle & Start;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10. The new bit enters at the LSB.
    assign w_feedback  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_step = {r_lfsr[14:0], w_feedback};

    // An all-zero seed would lock the LFSR at zero. Substitute the default seed instead.
    assign w_seed_eff = (Seed == 16'h0000) ? DEFAULT_SEED : Seed;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples the values from before the edge, so process order cannot matter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the default assignment at the top prevents a latch on any path
    // that does not assign w_state_next.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    // A zero-length burst goes straight to DONE and emits nothing.
                    w_state_next = (Num_Words != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_handshake && w_last_word) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // ------------------------------------------------------------------------
    always_comb begin
        Out_Valid = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (r_state)
            S_RUN: begin
                Out_Valid = 1'b1;
                Busy      = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Out_Valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // LFSR register
    // ------------------------------------------------------------------------
    // The seed load takes effect on the Start edge too, so a combined
    // Seed_Load+Start burst emits the loaded seed as its first word. The
    // state advances only on an accepted transfer, so a stalled pair holds steady.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_lfsr <= DEFAULT_SEED;
        end else if (w_in_idle && Seed_Load) begin
            r_lfsr <= w_seed_eff;
        end else if (w_handshake) begin
            r_lfsr <= w_lfsr_step;
        end
    end

    // ------------------------------------------------------------------------
    // Remaining-words counter
    // ------------------------------------------------------------------------
    // It is loaded only for a non-zero count. The count decrements once per
    // accepted word and never wraps, because RUN leaves at a count of 1.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_remaining <= '0;
        end else if (w_start_burst && (Num_Words != '0)) begin
            r_remaining <= Num_Words;
        end else if (w_handshake) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Data and shift-magnitude outputs
    // ------------------------------------------------------------------------
    assign Data_Out = r_lfsr;

`ifdef SHIFT_MAG_COUNT_EN
    logic [3:0] r_mag_cnt;

    // The counter wraps 15 -> 0 through natural 4-bit overflow.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mag_cnt <= 4'd0;
        end else if (w_start_burst) begin
            r_mag_cnt <= 4'd0;
        end else if (w_handshake) begin
            r_mag_cnt <= r_mag_cnt + 4'd1;
        end
    end

    assign Shift_Mag = r_mag_cnt;
`else
    assign Shift_Mag = r_lfsr[3:0];
`endif

endmodule

// File: tb/tb_lfsr_shift_source.sv
module tb_lfsr_shift_source;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Seed_Load;
    logic [15:0] Seed;
    logic        Start;
    logic [15:0] Num_Words;
    logic        Out_Ready;
    logic        Out_Valid;
    logic [15:0] Data_Out;
    logic [3:0]  Shift_Mag;
    logic        Busy;
    logic        Done;

    int tests_run    = 0;
    int tests_failed = 0;

    lfsr_shift_source #(
        .DEFAULT_SEED(16'hACE1),
        .CNT_W       (16)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Seed_Load(Seed_Load),
        .Seed     (Seed),
        .Start    (Start),
        .Num_Words(Num_Words),
        .Out_Ready(Out_Ready),
        .Out_Valid(Out_Valid),
        .Data_Out (Data_Out),
        .Shift_Mag(Shift_Mag),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR step for the long burst, written from the polynomial taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Expected magnitude for word idx of a burst whose data word is d.
    function automatic logic [3:0] exp_mag(input logic [15:0] d, input int idx);
`ifdef SHIFT_MAG_COUNT_EN
        return 4'(idx);
`else
        return d[3:0];
`endif
    endfunction

    // Inputs change on the falling edge. Outputs are also sampled there.
    task automatic start_burst(input logic [15:0] n);
        @(negedge Clk);
        Start     = 1'b1;
        Num_Words = n;
        @(negedge Clk);
        Start     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        tests_run++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b expected 0 0 0", Out_Valid, Busy, Done);
        end
        tests_run++;
        if (Data_Out !== 16'hACE1) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected acе1", Data_Out);
        end
        Rst = 1'b0;
    endtask

    task automatic test_basic_burst();
        logic [15:0] exp [3];
        exp[0] = 16'hACE1; exp[1] = 16'h59C3; exp[2] = 16'hB387;
        Out_Ready = 1'b1;
        start_burst(16'd3);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (Out_Valid !== 1'b1 || Busy !== 1'b1 || Data_Out !== exp[i] ||
                Shift_Mag !== exp_mag(exp[i], i)) begin
                tests_failed++;
                $display("FAIL basic_word%0d: got v=%b b=%b d=%h m=%0d expected v=1 b=1 d=%h m=%0d",
                         i, Out_Valid, Busy, Data_Out, Shift_Mag, exp[i], exp_mag(exp[i], i));
            end
            @(negedge Clk);
        end
        tests_run++;
        if (Out_Valid !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: got v=%b done=%b busy=%b expected 0 1 0", Out_Valid, Done, Busy);
        end
        @(negedge Clk);
        tests_run++;
        if (Out_Valid !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: got v=%b done=%b expected 0 0", Out_Valid, Done);
        end
    endtask

    task automatic test_stall();
        do_reset();
        Out_Ready = 1'b1;
        start_burst(16'd3);
        tests_run++;
        if (Data_Out !== 16'hACE1 || Out_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_word0: got v=%b d=%h expected v=1 d=ace1", Out_Valid, Data_Out);
        end
        @(negedge Clk);
        // Stall word 2. Seed_Load and Start are also asserted and must be ignored in RUN.
        Out_Ready = 1'b0;
        Seed_Load = 1'b1; Seed = 16'hFFFF;
        Start     = 1'b1; Num_Words = 16'd7;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (Data_Out !== 16'h59C3 || Out_Valid !== 1'b1 || Shift_Mag !== exp_mag(16'h59C3, 1)) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got v=%b d=%h m=%0d expected v=1 d=59c3 m=%0d",
                         k, Out_Valid, Data_Out, Shift_Mag, exp_mag(16'h59C3, 1));
            end
            @(negedge Clk);
        end
        Out_Ready = 1'b1;
        Seed_Load = 1'b0;
        Start     = 1'b0;
        tests_run++;
        if (Data_Out !== 16'h59C3 || Out_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got v=%b d=%h expected v=1 d=59c3", Out_Valid, Data_Out);
        end
        @(negedge Clk);
        tests_run++;
        if (Data_Out !== 16'hB387 || Out_Valid !== 1'b1 || Shift_Mag !== exp_mag(16'hB387, 2)) begin
            tests_failed++;
            $display("FAIL stall_word2: got v=%b d=%h m=%0d expected v=1 d=b387 m=%0d",
                     Out_Valid, Data_Out, Shift_Mag, exp_mag(16'hB387, 2));
        end
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b1 || Out_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_done: got done=%b v=%b expected 1 0", Done, Out_Valid);
        end
        @(negedge Clk);
    endtask

    task automatic test_zero_seed();
        @(negedge Clk);
        Seed_Load = 1'b1; Seed = 16'h0000;
        @(negedge Clk);
        Seed_Load = 1'b0;
        start_burst(16'd1);
        tests_run++;
        if (Data_Out !== 16'hACE1 || Out_Valid !== 1'b1 || Shift_Mag !== exp_mag(16'hACE1, 0)) begin
            tests_failed++;
            $display("FAIL zero_seed_word: got v=%b d=%h m=%0d expected v=1 d=ace1 m=%0d",
                     Out_Valid, Data_Out, Shift_Mag, exp_mag(16'hACE1, 0));
        end
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b1 || Out_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_seed_done: got done=%b v=%b expected 1 0", Done, Out_Valid);
        end
        @(negedge Clk);
    endtask

    task automatic test_seed_and_start();
        @(negedge Clk);
        Seed_Load = 1'b1; Seed = 16'h1234;
        Start     = 1'b1; Num_Words = 16'd2;
        @(negedge Clk);
        Seed_Load = 1'b0; Start = 1'b0;
        tests_run++;
        if (Data_Out !== 16'h1234 || Out_Valid !== 1'b1 || Shift_Mag !== exp_mag(16'h1234, 0)) begin
            tests_failed++;
            $display("FAIL seed_start_word0: got v=%b d=%h m=%0d expected v=1 d=1234 m=%0d",
                     Out_Valid, Data_Out, Shift_Mag, exp_mag(16'h1234, 0));
        end
        @(negedge Clk);
        tests_run++;
        if (Data_Out !== 16'h2469 || Out_Valid !== 1'b1 || Shift_Mag !== exp_mag(16'h2469, 1)) begin
            tests_failed++;
            $display("FAIL seed_start_word1: got v=%b d=%h m=%0d expected v=1 d=2469 m=%0d",
                     Out_Valid, Data_Out, Shift_Mag, exp_mag(16'h2469, 1));
        end
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b1 || Out_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_start_done: got done=%b v=%b expected 1 0", Done, Out_Valid);
        end
        @(negedge Clk);
    endtask

    task automatic test_zero_words();
        start_burst(16'd0);
        tests_run++;
        if (Done !== 1'b1 || Out_Valid !== 1'b0 || Busy !== 1'b0 || Data_Out !== 16'h48D2) begin
            tests_failed++;
            $display("FAIL zero_words_done: got done=%b v=%b b=%b d=%h expected 1 0 0 48d2",
                     Done, Out_Valid, Busy, Data_Out);
        end
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b0 || Out_Valid !== 1'b0 || Data_Out !== 16'h48D2) begin
            tests_failed++;
            $display("FAIL zero_words_idle: got done=%b v=%b d=%h expected 0 0 48d2", Done, Out_Valid, Data_Out);
        end
    endtask

    task automatic test_reset_mid_burst();
        Out_Ready = 1'b1;
        start_burst(16'd5);
        tests_run++;
        if (Data_Out !== 16'h48D2 || Out_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_word0: got v=%b d=%h expected v=1 d=48d2", Out_Valid, Data_Out);
        end
        @(negedge Clk);
        tests_run++;
        if (Data_Out !== 16'h91A4 || Out_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_word1: got v=%b d=%h expected v=1 d=91a4", Out_Valid, Data_Out);
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        tests_run++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Data_Out !== 16'hACE1) begin
            tests_failed++;
            $display("FAIL midrst_after: got v=%b b=%b done=%b d=%h expected 0 0 0 ace1",
                     Out_Valid, Busy, Done, Data_Out);
        end
        @(negedge Clk);
        tests_run++;
        if (Out_Valid !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stays_idle: got v=%b done=%b expected 0 0", Out_Valid, Done);
        end
    endtask

    task automatic test_long_burst();
        logic [15:0] s;
        do_reset();
        Out_Ready = 1'b1;
        start_burst(16'd18);
        s = 16'hACE1;
        for (int i = 0; i < 18; i++) begin
            tests_run++;
            if (Out_Valid !== 1'b1 || Data_Out !== s || Shift_Mag !== exp_mag(s, i)) begin
                tests_failed++;
                $display("FAIL long_word%0d: got v=%b d=%h m=%0d expected v=1 d=%h m=%0d",
                         i, Out_Valid, Data_Out, Shift_Mag, s, exp_mag(s, i));
            end
            s = lfsr_next(s);
            @(negedge Clk);
        end
        tests_run++;
        if (Done !== 1'b1 || Out_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_done: got done=%b v=%b expected 1 0", Done, Out_Valid);
        end
        @(negedge Clk);
    endtask

    initial begin
        Rst       = 1'b1;
        Seed_Load = 1'b0;
        Seed      = 16'h0000;
        Start     = 1'b0;
        Num_Words = 16'd0;
        Out_Ready = 1'b1;

        test_reset();
        test_basic_burst();
        test_stall();
        test_zero_seed();
        test_seed_and_start();
        test_zero_words();
        test_reset_mid_burst();
        test_long_burst();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lfsr_shift_source.md
Name: lfsr_shift_source

Overview:
Upstream stimulus stage for the 16-bit logical-right barrel shifter in the LFSR associative-memory datapath. It holds a 16-bit maximal-length Fibonacci LFSR and emits a burst of pseudo-random (data word, shift magnitude) pairs. Each pair drives the shifter's Inp and Shift_Mag inputs. Words are transferred with a valid/ready handshake, under control of a small start/done state machine.

Parameters:
DEFAULT_SEED, 16'hACE1, LFSR value after reset; also substituted whenever a zero seed is loaded.
CNT_W, 16, width of the word-count input and the internal remaining-words counter.

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
Seed_Load  input  1  load Seed into LFSR (honoured in IDLE only)
Seed  input  16  seed value; 16'h0000 is replaced by DEFAULT_SEED
Start  input  1  begin a burst (honoured in IDLE only)
Num_Words  input  CNT_W  words in burst, sampled on Start
Out_Ready  input  1  downstream accepts the current pair
Out_Valid  output  1  Data_Out/Shift_Mag hold a valid pair
Data_Out  output  16  current LFSR state, feeds shifter Inp
Shift_Mag  output  4  shift magnitude, feeds shifter Shift_Mag
Busy  output  1  high in RUN
Done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset (Rst=1 at a clock edge, any state, mid-burst included): state=IDLE; LFSR=DEFAULT_SEED; remaining=0; Out_Valid=0, Busy=0, Done=0. Data_Out shows the LFSR value.
- LFSR step: fb = s[15]^s[13]^s[12]^s[10], next = {s[14:0], fb}. Polynomial x^16+x^14+x^13+x^11+1, period 65535. The all-zero state is unreachable.
- Data_Out = LFSR state, driven combinationally from the register. Shift_Mag = LFSR[3:0] (default mode).
- IDLE:
  - Seed_Load=1: LFSR <= (Seed==0) ? DEFAULT_SEED : Seed.
  - Start=1 and Num_Words!=0: remaining <= Num_Words, go to RUN.
  - Start=1 and Num_Words==0: go to DONE; no word is emitted.
  - Seed_Load and Start in the same cycle: the seed is loaded and the burst starts. The first emitted word is the loaded seed.
- RUN:
  - Out_Valid=1, Busy=1.
  - Handshake occurs on a cycle with Out_Valid & Out_Ready. On that edge the LFSR advances one step and remaining decrements.
  - If remaining==1 at the handshake, go to DONE. Out_Valid is 0 in the next cycle.
  - While Out_Valid & ~Out_Ready, Data_Out and Shift_Mag are held stable. There is no timeout.
  - Seed_Load and Start are ignored.
- DONE: Done=1 for exactly one cycle, Out_Valid=0, Busy=0, then return to IDLE unconditionally. Seed_Load and Start are ignored.
- Latency: first valid pair appears the cycle after Start. Sustained throughput is one pair per cycle when Out_Ready stays high.
- LFSR state persists across bursts. A following Start without Seed_Load continues the sequence.
- remaining is CNT_W bits. Num_Words=2^CNT_W-1 is legal; there is no wrap.

Optional Feature:
Macro: SHIFT_MAG_COUNT_EN
- Defined: Shift_Mag comes from a 4-bit counter instead of LFSR[3:0].
  - Counter clears to 0 on reset and on an accepted Start.
  - Counter increments by 1 per handshake and wraps 15->0.
  - This sweeps every shift magnitude deterministically.
- Not defined: Shift_Mag = LFSR[3:0] and no counter is instantiated.

Test Plan:
- Reset, then Start with Num_Words=3 and Out_Ready=1 constant:
  - Data_Out sequence is 16'hACE1, 16'h59C3, 16'hB387.
  - Shift_Mag is 1, 3, 7.
  - Out_Valid is high for exactly 3 cycles, then Done pulses for 1 cycle.
- Same burst with Out_Ready low for 4 cycles during word 2: Data_Out holds 16'h59C3 through the stall, and the sequence is otherwise unchanged.
- Seed_Load with Seed=16'h0000, then Start with Num_Words=1: the single word is 16'hACE1.
- Seed_Load with Seed=16'h1234 and Start in the same cycle, Num_Words=2: the first word is 16'h1234.
- Start with Num_Words=0: Out_Valid never rises, Done pulses the next cycle, LFSR is unchanged. Also assert Rst mid-burst after 2 words: the next cycle shows IDLE, Out_Valid=0, Data_Out=16'hACE1.
- With SHIFT_MAG_COUNT_EN defined, a burst of 18 words: Shift_Mag reads 0,1,...,15,0,1 while Data_Out still follows the LFSR sequence.
